// File: rtl/mul_pkg.sv
// Shared encodings for the multiply functional unit: RV32M funct3 codes,
// multiplier type select and the issue controller state machine.
package mul_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;

    localparam logic [1:0] MT_UU = 2'b11;
    localparam logic [1:0] MT_SS = 2'b01;
    localparam logic [1:0] MT_SU = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        OUT   = 2'd2,
        DRAIN = 2'd3
    } mul_state_t;

    // Signedness of the operands follows the opcode; MUL's low half is sign-agnostic.
    function automatic logic [1:0] mt_of_funct3(input logic [2:0] f3);
        case (f3)
            F3_MULHSU: return MT_SU;
            F3_MULHU:  return MT_UU;
            default:   return MT_SS;
        endcase
    endfunction

endpackage

// File: rtl/mul_fu_controller.sv
// Issue-side controller for the iterative shift-add multiplier: takes one op
// from the RS, runs the multiplier handshake and broadcasts the result on the CDB.
module mul_fu_controller
    import mul_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int ROB_TAG_W = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [2:0]           req_funct3,
    input  logic [XLEN-1:0]      req_rs1,
    input  logic [XLEN-1:0]      req_rs2,
    input  logic [ROB_TAG_W-1:0] req_tag,
    input  logic                 flush,
    output logic                 mult_start,
    output logic [1:0]           mult_type,
    output logic [XLEN-1:0]      mult_a,
    output logic [XLEN-1:0]      mult_b,
    input  logic [2*XLEN-1:0]    mult_p,
    input  logic                 mult_done,
    output logic                 cdb_valid,
    input  logic                 cdb_ready,
    output logic [ROB_TAG_W-1:0] cdb_tag,
    output logic [XLEN-1:0]      cdb_data
);

    mul_state_t           state, state_n;
    logic                 squash, squash_n;
    logic                 hi_sel, hi_sel_n;
    logic                 start_n;
    logic [1:0]           type_n;
    logic [XLEN-1:0]      a_n, b_n, data_n;
    logic                 valid_n;
    logic [ROB_TAG_W-1:0] tag_n;
    logic                 accept;

    // Held low while reset is asserted so the RS never sees an accept during reset.
    assign req_ready = rst_n & (state == IDLE) & ~flush;
    assign accept    = req_valid & req_ready;

    always_comb begin
        state_n  = state;
        squash_n = squash;
        hi_sel_n = hi_sel;
        start_n  = mult_start;
        type_n   = mult_type;
        a_n      = mult_a;
        b_n      = mult_b;
        valid_n  = cdb_valid;
        tag_n    = cdb_tag;
        data_n   = cdb_data;

        case (state)
            IDLE: begin
                if (accept) begin
                    a_n      = req_rs1;
                    b_n      = req_rs2;
                    tag_n    = req_tag;
                    hi_sel_n = (req_funct3 != F3_MUL);
                    type_n   = mt_of_funct3(req_funct3);
                    start_n  = 1'b1;
                    squash_n = 1'b0;
                    state_n  = BUSY;
                end
            end
            BUSY: begin
                // The multiplier cannot abort, so a flush only marks the result as dead.
                if (flush) squash_n = 1'b1;
                if (mult_done) begin
                    start_n  = 1'b0;
                    data_n   = hi_sel ? mult_p[2*XLEN-1:XLEN] : mult_p[XLEN-1:0];
                    squash_n = 1'b0;
                    if (squash || flush) begin
                        state_n = DRAIN;
                    end else begin
                        valid_n = 1'b1;
                        state_n = OUT;
                    end
                end
            end
            OUT: begin
                if (flush || cdb_ready) begin
                    valid_n = 1'b0;
                    state_n = IDLE;
                end
            end
            DRAIN: begin
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            squash     <= 1'b0;
            hi_sel     <= 1'b0;
            mult_start <= 1'b0;
            mult_type  <= 2'b00;
            mult_a     <= '0;
            mult_b     <= '0;
            cdb_valid  <= 1'b0;
            cdb_tag    <= '0;
            cdb_data   <= '0;
        end else begin
            state      <= state_n;
            squash     <= squash_n;
            hi_sel     <= hi_sel_n;
            mult_start <= start_n;
            mult_type  <= type_n;
            mult_a     <= a_n;
            mult_b     <= b_n;
            cdb_valid  <= valid_n;
            cdb_tag    <= tag_n;
            cdb_data   <= data_n;
        end
    end

endmodule

// File: tb/tb_mul_fu_controller.sv
// Scoreboard bench for mul_fu_controller with a behavioural iterative multiplier.
module tb_mul_fu_controller;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_funct3;
    logic [31:0] req_rs1;
    logic [31:0] req_rs2;
    logic [4:0]  req_tag;
    logic        flush;
    logic        mult_start;
    logic [1:0]  mult_type;
    logic [31:0] mult_a;
    logic [31:0] mult_b;
    logic [63:0] mult_p;
    logic        mult_done;
    logic        cdb_valid;
    logic        cdb_ready;
    logic [4:0]  cdb_tag;
    logic [31:0] cdb_data;

    mul_fu_controller #(.XLEN(32), .ROB_TAG_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_tag(req_tag),
        .flush(flush),
        .mult_start(mult_start), .mult_type(mult_type), .mult_a(mult_a), .mult_b(mult_b),
        .mult_p(mult_p), .mult_done(mult_done),
        .cdb_valid(cdb_valid), .cdb_ready(cdb_ready), .cdb_tag(cdb_tag), .cdb_data(cdb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural multiplier: done after a fixed latency, held while start stays high.
    localparam int LAT = 4;
    int          mcnt;
    logic [63:0] sa, sb;
    always @(posedge clk) begin
        if (!rst_n) begin
            mcnt      <= 0;
            mult_done <= 1'b0;
            mult_p    <= '0;
        end else if (!mult_start) begin
            mcnt      <= 0;
            mult_done <= 1'b0;
        end else if (!mult_done) begin
            if (mcnt == LAT) begin
                sa = (mult_type[0]) ? {{32{mult_a[31]}}, mult_a} : {32'b0, mult_a};
                sb = (mult_type == 2'b01) ? {{32{mult_b[31]}}, mult_b} : {32'b0, mult_b};
                if (mult_type == 2'b11) sa = {32'b0, mult_a};
                if (mult_type == 2'b10) sa = {{32{mult_a[31]}}, mult_a};
                mult_p    <= sa * sb;
                mult_done <= 1'b1;
            end else begin
                mcnt <= mcnt + 1;
            end
        end
    end

    int          n_chk = 0;
    int          n_fail = 0;
    int          n_bcast = 0;
    logic [36:0] exp_q[$];
    logic [1:0]  exp_mt = 2'b01;
    logic [31:0] exp_a = '0, exp_b = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every CDB handshake and checks handshake invariants.
    logic        prev_valid = 1'b0, prev_done = 1'b0, prev_start = 1'b0, prev_rst = 1'b0;
    logic [36:0] e;
    always @(negedge clk) begin
        if (rst_n) begin
            if (cdb_valid && cdb_ready) begin
                n_bcast++;
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_bcast: tag %0d data 0x%08h, none expected", cdb_tag, cdb_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("cdb_tag", {27'b0, cdb_tag}, {27'b0, e[36:32]});
                    chk("cdb_data", cdb_data, e[31:0]);
                end
            end
            if (mult_start) begin
                chk("mult_type", {30'b0, mult_type}, {30'b0, exp_mt});
                chk("mult_a", mult_a, exp_a);
                chk("mult_b", mult_b, exp_b);
            end
            if (cdb_valid && !prev_valid) chk("cdb_after_done", {31'b0, prev_done}, 32'd1);
            if (prev_rst && prev_start && !mult_start) chk("start_held_to_done", {31'b0, prev_done}, 32'd1);
        end
        prev_valid = cdb_valid;
        prev_done  = mult_done;
        prev_start = mult_start;
        prev_rst   = rst_n;
    end

    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, input logic [31:0] exp, input bit track);
        bit ok = 0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_funct3 = f3; req_rs1 = a; req_rs2 = b; req_tag = tag;
        exp_a = a; exp_b = b;
        exp_mt = (f3 == 3'b011) ? 2'b11 : (f3 == 3'b010) ? 2'b10 : 2'b01;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1;
                if (track) exp_q.push_back({tag, exp});
            end
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (!ok) begin
            n_chk++; n_fail++;
            $display("FAIL issue_timeout: req_ready never high, tag %0d", tag);
        end
        @(negedge clk);
        chk("start_latency", {31'b0, mult_start}, 32'd1);
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (req_ready && exp_q.size() == 0) ok = 1;
        end
        if (!ok) begin
            n_chk++; n_fail++;
            $display("FAIL idle_timeout: pending %0d expected results", exp_q.size());
        end
    endtask

    task automatic wait_sig(input string name, input bit which);
        bit ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if ((which == 0 && cdb_valid) || (which == 1 && mult_done)) ok = 1;
        end
        if (!ok) begin
            n_chk++; n_fail++;
            $display("FAIL %s: timeout waiting", name);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, {31'b0, req_ready}, 32'd0);
        chk({tag, "_start"}, {31'b0, mult_start}, 32'd0);
        chk({tag, "_type"}, {30'b0, mult_type}, 32'd0);
        chk({tag, "_a"}, mult_a, 32'd0);
        chk({tag, "_b"}, mult_b, 32'd0);
        chk({tag, "_cdb_valid"}, {31'b0, cdb_valid}, 32'd0);
        chk({tag, "_cdb_tag"}, {27'b0, cdb_tag}, 32'd0);
        chk({tag, "_cdb_data"}, cdb_data, 32'd0);
    endtask

    int          b0;
    logic [4:0]  hold_tag;
    logic [31:0] hold_data;

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_funct3 = 3'b000; req_rs1 = '0; req_rs2 = '0;
        req_tag = '0; flush = 1'b0; cdb_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        @(posedge clk); #1 rst_n = 1'b1;

        // Directed ops: tag, operands and hand-computed results.
        wait_idle();
        b0 = n_bcast;
        issue(3'b000, 32'd7, 32'd6, 5'd3, 32'h0000002A, 1);
        wait_idle();
        chk("mul_single_pulse", n_bcast - b0, 32'd1);
        chk("ready_after_op", {31'b0, req_ready}, 32'd1);
        issue(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4, 32'hFFFFFFFE, 1);
        wait_idle();
        issue(3'b001, 32'hFFFFFFFE, 32'd3, 5'd5, 32'hFFFFFFFF, 1);
        wait_idle();
        issue(3'b000, 32'hFFFFFFFE, 32'd3, 5'd6, 32'hFFFFFFFA, 1);
        wait_idle();
        issue(3'b010, 32'hFFFFFFFF, 32'd2, 5'd7, 32'hFFFFFFFF, 1);
        wait_idle();

        // Flush in IDLE blocks acceptance.
        @(posedge clk); #1 flush = 1'b1; req_valid = 1'b1;
        @(negedge clk);
        chk("flush_idle_ready", {31'b0, req_ready}, 32'd0);
        @(posedge clk); #1 flush = 1'b0; req_valid = 1'b0;

        // CDB backpressure: result held stable, single broadcast.
        wait_idle();
        cdb_ready = 1'b0;
        b0 = n_bcast;
        issue(3'b011, 32'h80000000, 32'd4, 5'd12, 32'h00000002, 1);
        wait_sig("bp_valid_timeout", 0);
        hold_tag = cdb_tag; hold_data = cdb_data;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", {31'b0, cdb_valid}, 32'd1);
            chk("bp_tag", {27'b0, cdb_tag}, {27'b0, hold_tag});
            chk("bp_data", cdb_data, hold_data);
            chk("bp_req_ready", {31'b0, req_ready}, 32'd0);
        end
        @(posedge clk); #1 cdb_ready = 1'b1;
        wait_idle();
        chk("bp_single_bcast", n_bcast - b0, 32'd1);

        // Flush during BUSY: result dropped, one DRAIN cycle, then next op works.
        b0 = n_bcast;
        issue(3'b000, 32'd5, 32'd5, 5'd9, 32'd25, 0);
        repeat (2) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        wait_sig("flush_done_timeout", 1);
        @(negedge clk);
        chk("drain_start", {31'b0, mult_start}, 32'd0);
        chk("drain_valid", {31'b0, cdb_valid}, 32'd0);
        chk("drain_ready", {31'b0, req_ready}, 32'd0);
        @(negedge clk);
        chk("drain_one_cycle", {31'b0, req_ready}, 32'd1);
        chk("flush_no_bcast", n_bcast - b0, 32'd0);
        issue(3'b000, 32'd3, 32'd4, 5'd10, 32'd12, 1);
        wait_idle();

        // Flush while waiting in OUT: valid drops, nothing broadcast.
        cdb_ready = 1'b0;
        b0 = n_bcast;
        issue(3'b000, 32'd2, 32'd2, 5'd11, 32'd4, 0);
        wait_sig("out_flush_valid_timeout", 0);
        @(posedge clk); #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        chk("out_flush_valid", {31'b0, cdb_valid}, 32'd0);
        chk("out_flush_ready", {31'b0, req_ready}, 32'd1);
        cdb_ready = 1'b1;
        chk("out_flush_no_bcast", n_bcast - b0, 32'd0);

        // Reset in the middle of BUSY.
        issue(3'b001, 32'h12345678, 32'h9ABCDEF0, 5'd13, 32'h0, 0);
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("midrst");
        @(posedge clk); #1 rst_n = 1'b1;
        exp_q.delete();
        issue(3'b000, 32'h00010000, 32'h00000100, 5'd14, 32'h01000000, 1);
        wait_idle();

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
